// File: rtl/usiq_sequencer.sv
// Upstream IQ sequencer: captures one sample set per strobe and
// serialises it as I0,Q0,I1,Q1,... onto the IQ FIFO write port.
module usiq_sequencer #(
    parameter int NR   = 4,
    parameter int OVFW = 8
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [2:0]      nrx,
    input  logic            rx_strobe,
    input  logic [NR*48-1:0] rx_tdata,
    output logic [23:0]     usiq_tdata,
    output logic            usiq_tvalid,
    input  logic            usiq_tready,
    output logic            usiq_tlast,
    output logic [1:0]      usiq_tuser,
    output logic            busy,
    output logic [OVFW-1:0] overrun_count
);

    localparam int HW = 8 * 48;

    typedef enum logic [1:0] {
        IDLE,
        SEND_I,
        SEND_Q
    } state_t;

    state_t state, state_nx;

    logic [HW-1:0]   hold, hold_nx, rx_pad;
    logic [2:0]      idx, idx_nx, last, last_nx, nrx_c;
    logic [23:0]     tdata_nx;
    logic            tvalid_nx, tlast_nx, busy_nx;
    logic [1:0]      tuser_nx;
    logic [OVFW-1:0] ovf_nx;
    logic            pend, pend_nx;
    logic            xfer, final_xfer, accept, drop;

    // Pad to eight receivers so a 3-bit index always selects in range.
    assign rx_pad = HW'(rx_tdata);

    always_comb begin
        state_nx   = state;
        hold_nx    = hold;
        idx_nx     = idx;
        last_nx    = last;
        tdata_nx   = usiq_tdata;
        tvalid_nx  = usiq_tvalid;
        tlast_nx   = usiq_tlast;
        tuser_nx   = usiq_tuser;
        ovf_nx     = overrun_count;
        pend_nx    = pend;

        xfer       = usiq_tvalid & usiq_tready;
        final_xfer = (state == SEND_Q) && xfer && (idx == last);
        accept     = rx_strobe && ((state == IDLE) || final_xfer);
        drop       = rx_strobe && !accept;
        nrx_c      = ({1'b0, nrx} >= 4'(NR)) ? 3'(NR - 1) : nrx;

        if (drop) begin
            pend_nx = 1'b1;
            if (~&overrun_count)
                ovf_nx = overrun_count + 1'b1;
        end

        unique case (state)
            IDLE: ;
            SEND_I: begin
                if (xfer) begin
                    tdata_nx = hold[48*int'(idx) +: 24];
                    tlast_nx = (idx == last);
                    tuser_nx = 2'b00;
                    state_nx = SEND_Q;
                end
            end
            SEND_Q: begin
                if (xfer) begin
                    tlast_nx = 1'b0;
                    tuser_nx = 2'b00;
                    if (idx == last) begin
                        tvalid_nx = 1'b0;
                        tdata_nx  = '0;
                        state_nx  = IDLE;
                    end else begin
                        idx_nx   = idx + 3'd1;
                        tdata_nx = hold[48*int'(idx_nx)+24 +: 24];
                        state_nx = SEND_I;
                    end
                end
            end
            default: state_nx = IDLE;
        endcase

        // A capture on the final transfer overrides the return to IDLE.
        if (accept) begin
            hold_nx   = rx_pad;
            last_nx   = nrx_c;
            idx_nx    = 3'd0;
            tdata_nx  = rx_pad[47:24];
            tvalid_nx = 1'b1;
            tlast_nx  = 1'b0;
            tuser_nx  = pend ? 2'b01 : 2'b00;
            pend_nx   = 1'b0;
            state_nx  = SEND_I;
        end

        busy_nx = (state_nx != IDLE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= IDLE;
            hold          <= '0;
            idx           <= '0;
            last          <= '0;
            usiq_tdata    <= '0;
            usiq_tvalid   <= 1'b0;
            usiq_tlast    <= 1'b0;
            usiq_tuser    <= 2'b00;
            busy          <= 1'b0;
            overrun_count <= '0;
            pend          <= 1'b0;
        end else begin
            state         <= state_nx;
            hold          <= hold_nx;
            idx           <= idx_nx;
            last          <= last_nx;
            usiq_tdata    <= tdata_nx;
            usiq_tvalid   <= tvalid_nx;
            usiq_tlast    <= tlast_nx;
            usiq_tuser    <= tuser_nx;
            busy          <= busy_nx;
            overrun_count <= ovf_nx;
            pend          <= pend_nx;
        end
    end

endmodule

// File: tb/tb_usiq_sequencer.sv
// Self-checking bench for usiq_sequencer: directed plan steps plus
// randomized traffic against a word-queue reference model.
module tb_usiq_sequencer;

    localparam int NR   = 4;
    localparam int OVFW = 8;
    localparam int OMAX = (1 << OVFW) - 1;

    logic            clk = 1'b0;
    logic            rst;
    logic [2:0]      nrx;
    logic            rx_strobe;
    logic [NR*48-1:0] rx_tdata;
    logic [23:0]     usiq_tdata;
    logic            usiq_tvalid;
    logic            usiq_tready;
    logic            usiq_tlast;
    logic [1:0]      usiq_tuser;
    logic            busy;
    logic [OVFW-1:0] overrun_count;

    always #5 clk = ~clk;

    usiq_sequencer #(.NR(NR), .OVFW(OVFW)) dut (
        .clk(clk),
        .rst(rst),
        .nrx(nrx),
        .rx_strobe(rx_strobe),
        .rx_tdata(rx_tdata),
        .usiq_tdata(usiq_tdata),
        .usiq_tvalid(usiq_tvalid),
        .usiq_tready(usiq_tready),
        .usiq_tlast(usiq_tlast),
        .usiq_tuser(usiq_tuser),
        .busy(busy),
        .overrun_count(overrun_count)
    );

    typedef struct {
        logic [23:0] d;
        logic        l;
        logic [1:0]  u;
    } word_t;

    // Words still owed to the FIFO, head is the one on the bus now.
    word_t q[$];
    int    cnt;
    bit    pend;
    bit    live;
    int    checks;
    int    errors;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic set_pattern();
        for (int k = 0; k < NR; k++) begin
            rx_tdata[48*k+24 +: 24] = 24'h100000 + 24'(k);
            rx_tdata[48*k +: 24]    = 24'h200000 + 24'(k);
        end
    endtask

    task automatic set_random();
        for (int b = 0; b < NR*48; b++)
            rx_tdata[b] = 1'($urandom_range(0, 1));
    endtask

    task automatic step(input logic s, input logic r, input logic rs);
        bit xf;
        bit fin;
        int n;
        if (live) begin
            chk("tvalid", usiq_tvalid, q.size() > 0);
            if (q.size() > 0) begin
                chk("tdata", usiq_tdata, q[0].d);
                chk("tlast", usiq_tlast, q[0].l);
                chk("tuser", usiq_tuser, q[0].u);
            end
            chk("busy", busy, q.size() > 0);
            chk("overrun", overrun_count, cnt);
        end
        rst         = rs;
        rx_strobe   = s;
        usiq_tready = r;
        if (rs) begin
            q.delete();
            cnt  = 0;
            pend = 0;
            live = 1;
        end else begin
            xf  = (q.size() > 0) && r;
            fin = xf && (q.size() == 1);
            if (xf)
                void'(q.pop_front());
            if (s && (q.size() == 0 || fin)) begin
                n = ((int'(nrx) >= NR) ? NR - 1 : int'(nrx)) + 1;
                for (int k = 0; k < n; k++) begin
                    q.push_back('{rx_tdata[48*k+24 +: 24], 1'b0,
                                  (k == 0 && pend) ? 2'b01 : 2'b00});
                    q.push_back('{rx_tdata[48*k +: 24], k == n - 1,
                                  2'b00});
                end
                pend = 0;
            end else if (s) begin
                if (cnt < OMAX)
                    cnt++;
                pend = 1;
            end
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        checks = 0;
        errors = 0;
        live   = 0;
        cnt    = 0;
        pend   = 0;
        rst = 1'b1;
        rx_strobe = 1'b0;
        usiq_tready = 1'b0;
        nrx = 3'd0;
        rx_tdata = '0;
        @(negedge clk);
        step(0, 0, 1);
        step(0, 0, 1);

        // Full set, FIFO always ready.
        set_pattern();
        nrx = 3'd3;
        step(1, 1, 0);
        repeat (10) step(0, 1, 0);

        // Same set under alternating backpressure.
        step(1, 1, 0);
        for (int i = 0; i < 20; i++)
            step(0, (i % 2) == 1, 0);

        // Clamped receiver count, then single receiver.
        nrx = 3'd7;
        step(1, 1, 0);
        repeat (10) step(0, 1, 0);
        nrx = 3'd0;
        step(1, 1, 0);
        repeat (4) step(0, 1, 0);

        // Two dropped sets while stalled, then tagged next set.
        nrx = 3'd3;
        step(1, 0, 0);
        step(0, 0, 0);
        step(1, 0, 0);
        repeat (3) step(0, 0, 0);
        step(1, 0, 0);
        repeat (12) step(0, 1, 0);
        set_random();
        step(1, 1, 0);
        repeat (10) step(0, 1, 0);

        // Strobe landing on the final transfer, then reset mid-set.
        set_pattern();
        step(1, 1, 0);
        for (int i = 0; i < 20; i++)
            step(q.size() == 1, 1, 0);
        step(0, 1, 1);
        step(0, 1, 0);
        step(1, 1, 0);
        repeat (10) step(0, 1, 0);

        // Random mixed traffic with occasional reset.
        repeat (3000) begin
            nrx = 3'($urandom_range(0, 7));
            set_random();
            step($urandom_range(0, 5) == 0, $urandom_range(0, 2) != 0,
                 $urandom_range(0, 400) == 0);
        end

        // Heavy stalls to push the overrun counter into saturation.
        step(0, 1, 1);
        repeat (1500) begin
            nrx = 3'($urandom_range(0, 7));
            set_random();
            step($urandom_range(0, 1) == 1, $urandom_range(0, 7) == 0, 0);
        end
        repeat (20) step(0, 1, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/usiq_sequencer.md
Name: usiq_sequencer

Overview:
- Collects one sample set from all active receivers on each decimated sample strobe.
- Serialises the set into the 24-bit upstream IQ FIFO write port as I0,Q0,I1,Q1,…, with tlast on the final word.
- Sits between the receiver DDC outputs and the upstream IQ FIFO. It is the only writer of that FIFO and paces the FIFO's AXI-stream style write side.
- Flags dropped sets when FIFO backpressure stalls the sequencer past the next strobe.

Parameters:
- NR, 4, number of physical receiver channels (1..8).
- OVFW, 8, width of the saturating overrun counter.

Ports:
- clk  input  1  system clock; the single clock of this block.
- rst  input  1  synchronous active-high reset.
- nrx  input  3  active receivers minus 1; sampled only when a strobe is accepted; values ≥NR clamp to NR-1.
- rx_strobe  input  1  single-cycle pulse: a new sample set is present on rx_tdata.
- rx_tdata  input  NR*48  receiver k occupies bits [48k+47:48k]: I is [48k+47:48k+24], Q is [48k+23:48k].
- usiq_tdata  output  24  word to FIFO.
- usiq_tvalid  output  1  word valid.
- usiq_tready  input  1  FIFO can accept a word (driven from FIFO occupancy threshold).
- usiq_tlast  output  1  last word of the set.
- usiq_tuser  output  2  word tag: 00 = normal; 01 = first word of a set that follows one or more dropped sets.
- busy  output  1  a set is captured and not yet fully transferred.
- overrun_count  output  OVFW  saturating count of dropped sets.

Behaviour:
- Reset (rst=1 at a clk edge):
  - State goes to IDLE; all outputs become 0.
  - Holding registers are cleared, and any in-flight set is discarded without tlast.
  - The drop-pending flag is cleared.
  - rst takes priority over rx_strobe in the same cycle.
- Handshake:
  - A word transfers on a clk edge where usiq_tvalid & usiq_tready.
  - While usiq_tvalid=1 and usiq_tready=0, usiq_tdata, usiq_tlast and usiq_tuser hold stable.
  - usiq_tvalid never drops without a transfer, except by reset.
  - All outputs are registered.
- State machine: IDLE, SEND_I, SEND_Q, with receiver index idx (3 bits) and latched count n = clamp(nrx)+1.
  - IDLE + rx_strobe: capture rx_tdata and n; idx=0; go to SEND_I. Next cycle: usiq_tvalid=1 and usiq_tdata=I0, so latency from strobe to first valid word is 1 cycle.
  - SEND_I + transfer: present Q[idx]; go to SEND_Q.
  - SEND_Q + transfer with idx<n-1: idx+1; present I[idx+1]; go to SEND_I.
  - SEND_Q + transfer with idx=n-1: the word just transferred carried usiq_tlast=1. Go to IDLE; usiq_tvalid=0 next cycle unless a strobe is accepted this cycle (see below).
- tuser:
  - If the drop-pending flag is set when a set is captured, the I0 word carries usiq_tuser=01 and the flag clears on capture.
  - All other words carry 00.
- Overrun:
  - rx_strobe while busy=1 and not on the final transfer cycle: the new set is ignored and the in-flight set is unaffected.
  - overrun_count increments, saturating at all-ones. The drop-pending flag is set.
- Strobe on the final transfer cycle (last Q transferring): the set is accepted, not counted as an overrun. I0 of the new set is presented the next cycle, with no idle bubble.
- busy:
  - Goes to 1 the cycle after capture.
  - Goes to 0 the cycle after the final transfer, unless a back-to-back capture keeps it at 1.
- Runtime nrx changes only take effect at the next accepted strobe.
- rx_tdata is ignored except on capture, so upstream may change it freely.
- Single-receiver case: n=1 gives two words, I0 then Q0, with tlast on Q0.

Test Plan:
- rst, then NR=4, nrx=3, strobe with I_k=24'h100000+k and Q_k=24'h200000+k, usiq_tready=1 -> 8 words on consecutive cycles starting 1 cycle after the strobe: 100000,200000,100001,…,200003. tlast only on 200003; tuser=00 throughout; busy low 1 cycle after the last word.
- Same set with usiq_tready toggling 1,0,1,0 -> the same 8-word order, with words held stable during every tready=0 cycle and no word duplicated or skipped.
- nrx=7 with NR=4 -> 8 words (clamped to 4 receivers). Then nrx=0 -> 2 words, with tlast on Q0.
- tready=0 held, with a strobe mid-set and a second strobe later -> overrun_count=2 and the in-flight set completes intact. The next accepted set's I0 has tuser=01 and its remaining words have 00.
- Strobe exactly on the cycle the last Q transfers -> overrun_count unchanged and the new I0 is valid the very next cycle. Then rst asserted mid-set -> the next cycle has tvalid=0, busy=0 and overrun_count=0, and a subsequent strobe restarts at I0.
